serial_add_ctrl: RTL and testbench

//   Bit-serial addition controller. It time-multiplexes one external 1-bit

---
 rtl/serial_add_ctrl.sv | 92 +++++++++
 tb/tb_serial_add_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller driving one external full_adder cell, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, sum_q;
    logic [WIDTH-1:0] s_sh_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, run, last;
    assign run    = state_q == RUN;
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign s_sh_d = {fa_sum, s_sh_q[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy   = state_q != IDLE;
        done   = state_q == DONE;
        fa_a   = run ? a_sh_q[0] : 1'b0;
        fa_b   = run ? b_sh_q[0] : 1'b0;
        fa_cin = run ? carry_q : 1'b0;
        sum    = sum_q;
        cout   = cout_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (run) begin
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            s_sh_q  <= s_sh_d;
            carry_q <= fa_carry;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                sum_q  <= s_sh_d;
                cout_q <= fa_carry;
            end
        end
    end
`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ovf_q <= 1'b0;
        else if (run && last) ovf_q <= fa_carry ^ carry_q;
    end
    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl with a behavioural full_adder cell
// and a scoreboard of expected {cout, sum}; define SERIAL_ADD_OVF_EN to also check ovf.
module tb_serial_add_ctrl;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n, start, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout, fa_a, fa_b, fa_cin, fa_sum, fa_carry;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif
    int checks = 0, errors = 0, done_seen = 0, exp_done = 0;
    logic [W:0]   sb[$];
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_carry(fa_carry)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_carry = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts at an IDLE negedge, ends at the IDLE negedge after the DONE cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input bit hold);
        logic [W:0] r, e;
        logic       c;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        r = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        sb.push_back(r);
        c = tc;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("fa_a", fa_a, ta[k]);
            chk("fa_b", fa_b, tb_[k]);
            chk("fa_cin", fa_cin, c);
            chk("sum_hold", {cout, sum}, {prev_cout, prev_sum});
            c = (ta[k] & tb_[k]) | (c & (ta[k] ^ tb_[k]));
            if (hold) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 1);
        chk("fa_done", {fa_a, fa_b, fa_cin}, 0);
        chk("sb_size", sb.size(), 1);
        e = sb.pop_front();
        chk("sum", sum, e[W-1:0]);
        chk("cout", cout, e[W]);
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", ovf, (ta[W-1] == tb_[W-1]) && (r[W-1] != ta[W-1]));
`endif
        prev_sum = e[W-1:0];
        prev_cout = e[W];
        exp_done++;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("fa_idle", {fa_a, fa_b, fa_cin}, 0);
        chk("sum_idle", {cout, sum}, {prev_cout, prev_sum});
        chk("done_count", done_seen, exp_done);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", {cout, sum}, 0);
        chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h5A, 8'hA5, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        // start held high: inputs scrambled mid-run, accepts every WIDTH+2 cycles
        run_op(8'h3C, 8'h4B, 1'b1, 1'b1);
        run_op(8'h81, 8'h7E, 1'b0, 1'b1);
        run_op(8'h12, 8'h34, 1'b1, 1'b0);
        // reset while processing bit 4 of 0x0F+0x01
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", {cout, sum}, 0);
        chk("abort_fa", {fa_a, fa_b, fa_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0;
        @(negedge clk);
        chk("abort_no_done", done_seen, exp_done);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
